// File: rtl/bus_arbiter_rr_n_pkg.sv
// Shared bus-arbiter definitions: default sizes, active-low signal levels and reset level.
// The optional tenure limit is compiled in by defining BUS_ARB_TENURE_EN.
package bus_arbiter_rr_n_pkg;

    localparam int DEFAULT_NUM_MASTERS = 4;
    localparam int DEFAULT_MAX_TENURE  = 16;

    localparam logic ENABLE_      = 1'b0;
    localparam logic DISABLE_     = 1'b1;
    localparam logic RESET_ENABLE = 1'b1;

    // Owner index width; never zero so a 1-bit owner still exists for tiny configs.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_n_next_sel.sv
// rr_next_sel: combinational circular find-first over an active-high request vector,
// starting at i_start and wrapping; reusable by other round-robin arbiters.
module rr_next_sel #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    int         w_pos;
    logic [W-1:0] w_sel;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = W'(w_pos);
            if (!o_found && i_req[w_sel]) begin
                o_found = 1'b1;
                o_idx   = w_sel;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr_n.sv
// Round-robin bus arbiter with active-low request/grant; owner drives the shared bus mux.
// Define BUS_ARB_TENURE_EN to limit an owner to MAX_TENURE cycles under contention.
module bus_arbiter_rr_n
    import bus_arbiter_rr_n_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int MAX_TENURE  = DEFAULT_MAX_TENURE,
    localparam int OWNER_W    = owner_width(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] i_req_,
    output logic [NUM_MASTERS-1:0] o_grnt_,
    output logic [OWNER_W-1:0]     o_owner
);

    if (NUM_MASTERS < 2 || MAX_TENURE < 1) begin : g_bad_param
        $error("bus_arbiter_rr_n: NUM_MASTERS must be >= 2 and MAX_TENURE >= 1");
    end

    logic [OWNER_W-1:0]     r_owner;
    logic [OWNER_W-1:0]     w_owner_nxt;
    logic [OWNER_W-1:0]     w_start;
    logic [OWNER_W-1:0]     w_next_idx;
    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_grnt_;
    logic                   w_found;
    logic                   w_owner_req;
    logic                   w_others;
    logic                   w_expire;
    logic                   w_hit;

    always_comb begin
        w_req       = '0;
        w_owner_req = 1'b0;
        w_others    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_req[i] = (i_req_[i] == ENABLE_);
            if (r_owner == OWNER_W'(i)) begin
                w_owner_req = w_req[i];
            end else begin
                w_others = w_others | w_req[i];
            end
        end
    end

    // Search starts just past the owner, so the owner itself is always last in line.
    assign w_start = (r_owner == OWNER_W'(NUM_MASTERS - 1)) ? '0 : r_owner + OWNER_W'(1);

    rr_next_sel #(
        .N (NUM_MASTERS),
        .W (OWNER_W)
    ) u_next_sel (
        .i_req   (w_req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_next_idx)
    );

`ifdef BUS_ARB_TENURE_EN
    localparam int CNT_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TENURE - 1);

    logic [CNT_W-1:0] r_cnt;

    assign w_expire = (r_cnt == CNT_MAX) && w_others;

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            r_cnt <= '0;
        end else if (w_owner_nxt != r_owner) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_owner_nxt = r_owner;
        if ((!w_owner_req || w_expire) && w_others && w_found) begin
            w_owner_nxt = w_next_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            r_owner <= '0;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Unreachable owner codes (non power-of-two N) fall back to a grant for master 0.
    always_comb begin
        w_grnt_ = {NUM_MASTERS{DISABLE_}};
        w_hit   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_owner == OWNER_W'(i)) begin
                w_grnt_[i] = ENABLE_;
                w_hit      = 1'b1;
            end
        end
        if (!w_hit) begin
            w_grnt_[0] = ENABLE_;
        end
    end

    assign o_grnt_ = w_grnt_;
    assign o_owner = r_owner;

endmodule

// File: tb/tb_bus_arbiter_rr_n.sv
// Bench for bus_arbiter_rr_n (N=4, MAX_TENURE=4): directed vectors with literal
// expectations plus a run-length ownership model checked every cycle.
module tb_bus_arbiter_rr_n;

  localparam int N  = 4;
  localparam int MT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_;
  logic [N-1:0] grnt_;
  logic [1:0]   owner;

  int n_checks = 0;
  int n_pass   = 0;

  // model: current owner and how many consecutive cycles it has held the bus
  int m_owner = 0;
  int m_held  = 0;
  bit m_valid = 1'b0;
  int m_nxt;
  int m_cand;
  bit m_expire;

  int tenure_seq[8];
  int post_rst_seq[4];

  bus_arbiter_rr_n #(
    .NUM_MASTERS (N),
    .MAX_TENURE  (MT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req_  (req_),
    .o_grnt_ (grnt_),
    .o_owner (owner)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic int grant_of(input int own);
    return ((1 << N) - 1) ^ (1 << own);
  endfunction

  // behavioural model: circular search for the next requester after the owner
  always @(posedge clk) begin
    if (reset) begin
      m_owner = 0;
      m_held  = 1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_nxt = -1;
      for (int d = 1; d < N; d++) begin
        m_cand = (m_owner + d) % N;
        if (req_[m_cand] == 1'b0 && m_nxt < 0) m_nxt = m_cand;
      end
`ifdef BUS_ARB_TENURE_EN
      m_expire = (m_held >= MT);
`else
      m_expire = 1'b0;
`endif
      if ((req_[m_owner] == 1'b1 || m_expire) && m_nxt >= 0) begin
        m_owner = m_nxt;
        m_held  = 1;
      end else if (m_held < MT) begin
        m_held = m_held + 1;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_owner", int'(owner), m_owner);
      check("model_grnt_", int'(grnt_), grant_of(m_owner));
    end
  end

  // driver: change inputs just after a falling edge, return at the next falling edge
  task automatic apply(input logic rst, input logic [N-1:0] r);
    #1;
    reset = rst;
    req_  = r;
    @(negedge clk);
  endtask

  initial begin
`ifdef BUS_ARB_TENURE_EN
    tenure_seq   = '{0, 0, 0, 2, 2, 2, 2, 0};
    post_rst_seq = '{0, 0, 0, 2};
`else
    tenure_seq   = '{0, 0, 0, 0, 0, 0, 0, 0};
    post_rst_seq = '{0, 0, 0, 0};
`endif
    reset = 1'b1;
    req_  = 4'b1111;
    @(negedge clk);

    // 1: reset for two cycles, then hold
    apply(1'b1, 4'b1111);
    check("rst_owner", int'(owner), 0);
    check("rst_grnt_", int'(grnt_), 4'b1110);
    apply(1'b0, 4'b1111);
    check("post_rst_owner", int'(owner), 0);
    check("post_rst_grnt_", int'(grnt_), 4'b1110);

    // 2: everyone requests, then owner 0 releases
    apply(1'b0, 4'b0000);
    check("all_req_hold", int'(owner), 0);
    apply(1'b0, 4'b0001);
    check("release_owner", int'(owner), 1);
    check("release_grnt_", int'(grnt_), 4'b1101);

    // 3: reach owner 3, then wrap past idle m0 to m1, then park
    apply(1'b0, 4'b0111);
    check("to_m3_owner", int'(owner), 3);
    check("to_m3_grnt_", int'(grnt_), 4'b0111);
    apply(1'b0, 4'b1101);
    check("wrap_owner", int'(owner), 1);
    apply(1'b0, 4'b1111);
    check("park_owner", int'(owner), 1);
    check("park_grnt_", int'(grnt_), 4'b1101);

    // 4: circular order from owner+1 picks m2 over m0
    apply(1'b0, 4'b1010);
    check("circ_owner", int'(owner), 2);

    // 5: m0 and m2 contend
    apply(1'b0, 4'b1110);
    check("only_m0_owner", int'(owner), 0);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 4'b1010);
      check($sformatf("tenure_%0d", i), int'(owner), tenure_seq[i]);
    end

    // 6: reset mid-tenure with owner 2, counter 2
    apply(1'b0, 4'b1011);
    check("m2_take_owner", int'(owner), 2);
    apply(1'b0, 4'b1011);
    apply(1'b0, 4'b1011);
    check("m2_hold_owner", int'(owner), 2);
    apply(1'b1, 4'b1011);
    check("mid_rst_owner", int'(owner), 0);
    check("mid_rst_grnt_", int'(grnt_), 4'b1110);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 4'b1010);
      check($sformatf("cnt_cleared_%0d", i), int'(owner), post_rst_seq[i]);
    end

    // mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      apply(($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
